ccw_chain_sequencer: RTL and testbench

- Executes a channel program: fetches 64-bit CCWs from memory, loads command/count/data address into the channel datapath, pulses start, waits for completion, then follows command chaining.
- Sits between the S_AXI register block and the channel/DMA datapath; its memory port is muxed onto the M_AXI read channel when the byte DMA is idle.
- Removes per-CCW software intervention.

---
 rtl/channel_pkg.sv | 51 +++++
 rtl/ccw_fetch.sv | 55 +++++
 rtl/ccw_chain_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_ccw_chain_sequencer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_pkg.sv
// Shared definitions for the channel-program sequencer: CCW layout, device status bits,
// end-reason codes and FSM state encodings.
package channel_pkg;

    localparam int unsigned CcwCmdLsb   = 0;
    localparam int unsigned CcwFlagsLsb = 8;
    localparam int unsigned CcwCountLsb = 16;
    localparam int unsigned CcwAddrLsb  = 32;

    // Bit positions within the CCW flags byte
    localparam int unsigned FlagCc  = 6;
    localparam int unsigned FlagSli = 5;

    localparam logic [7:0] StsUnitExc    = 8'h01;
    localparam logic [7:0] StsUnitCheck  = 8'h02;
    localparam logic [7:0] StsModifier   = 8'h40;
    localparam logic [7:0] StsChanDevEnd = 8'h0C;

    localparam logic [2:0] ErrOk       = 3'd0;
    localparam logic [2:0] ErrFetch    = 3'd1;
    localparam logic [2:0] ErrCc       = 3'd2;
    localparam logic [2:0] ErrUnit     = 3'd3;
    localparam logic [2:0] ErrLimit    = 3'd4;
    localparam logic [2:0] ErrWatchdog = 3'd5;
    localparam logic [2:0] ErrAbort    = 3'd6;

    typedef enum logic [3:0] {
        StIdle,
        StFetchAr,
        StFetchR,
        StLoad,
        StStart,
        StArm,
        StRun,
        StEval,
        StEnd
    } seq_state_e;

    typedef enum logic [1:0] {
        FetchIdle,
        FetchAddr,
        FetchData
    } fetch_state_e;

    // Status modifier skips the next CCW; wraps modulo 2^32
    function automatic logic [31:0] next_ccw_addr(input logic [31:0] addr,
                                                  input logic [7:0]  status);
        return addr + (((status & StsModifier) != 8'h00) ? 32'd16 : 32'd8);
    endfunction

endpackage

// File: rtl/ccw_fetch.sv
// Single-beat AXI read engine for CCW fetches; req launches one read of addr and the
// response is reported for one cycle as {rsp_data, rsp_err}.
module ccw_fetch
    import channel_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        req,
    input  logic [31:0] addr,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] mem_araddr,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    input  logic [63:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    input  logic        mem_rvalid,
    output logic        mem_rready
);

    fetch_state_e state_q, state_d;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= FetchIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FetchIdle: if (req)         state_d = FetchAddr;
            FetchAddr: if (mem_arready) state_d = FetchData;
            FetchData: if (mem_rvalid)  state_d = FetchIdle;
            default:                    state_d = FetchIdle;
        endcase
    end

    // addr is held stable by the caller for the whole transaction
    assign mem_arvalid = (state_q == FetchAddr);
    assign mem_araddr  = mem_arvalid ? addr : 32'h0;
    assign mem_rready  = (state_q == FetchData);

    // rresp[1] set means SLVERR or DECERR; EXOKAY is treated as OKAY
    assign rsp_valid = mem_rready && mem_rvalid;
    assign rsp_data  = mem_rdata;
    assign rsp_err   = mem_rresp[1];

    logic unused_rresp;
    assign unused_rresp = mem_rresp[0];

endmodule

// File: rtl/ccw_chain_sequencer.sv
// Channel-program sequencer: fetches CCWs, drives the channel datapath and follows command
// chaining. Optional per-CCW watchdog enabled by defining SEQ_WATCHDOG_EN.
module ccw_chain_sequencer
    import channel_pkg::*;
#(
    parameter int unsigned START_WINDOW   = 16,
    parameter int unsigned MAX_CCWS       = 256,
    parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        seq_start,
    input  logic        seq_abort,
    input  logic [31:0] seq_addr,
    output logic        seq_busy,
    output logic        seq_done,
    output logic [2:0]  seq_error,
    output logic [31:0] seq_ccw_addr,
    output logic [15:0] seq_ccw_index,
    output logic [31:0] mem_araddr,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    input  logic [63:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    input  logic        mem_rvalid,
    output logic        mem_rready,
    output logic [7:0]  ccw_command,
    output logic [15:0] ccw_count,
    output logic [31:0] ccw_data_addr,
    output logic        channel_start,
    input  logic        channel_active,
    input  logic [1:0]  channel_condition_code,
    input  logic [7:0]  status_tdata,
    input  logic        status_tvalid
);

    localparam int unsigned ArmW = $clog2(START_WINDOW) + 1;

    seq_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] index_q, index_d;
    logic [2:0]  error_q, error_d;
    logic [7:0]  status_q, status_d;
    logic        abort_q, abort_d;
    logic [ArmW-1:0] arm_q, arm_d;
    logic [63:0] word_q, word_d;
    logic [7:0]  command_q, command_d;
    logic [15:0] count_q, count_d;
    logic [31:0] data_addr_q, data_addr_d;

    logic        fetch_req, rsp_valid, rsp_err, wd_expired, cc_flag;
    logic [63:0] rsp_data;

    ccw_fetch u_fetch (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .req         (fetch_req),
        .addr        (addr_q),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .mem_araddr  (mem_araddr),
        .mem_arvalid (mem_arvalid),
        .mem_arready (mem_arready),
        .mem_rdata   (mem_rdata),
        .mem_rresp   (mem_rresp),
        .mem_rvalid  (mem_rvalid),
        .mem_rready  (mem_rready)
    );

    assign cc_flag = word_q[CcwFlagsLsb + FlagCc];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            index_q     <= '0;
            error_q     <= ErrOk;
            status_q    <= '0;
            abort_q     <= 1'b0;
            arm_q       <= '0;
            word_q      <= '0;
            command_q   <= '0;
            count_q     <= '0;
            data_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            index_q     <= index_d;
            error_q     <= error_d;
            status_q    <= status_d;
            abort_q     <= abort_d;
            arm_q       <= arm_d;
            word_q      <= word_d;
            command_q   <= command_d;
            count_q     <= count_d;
            data_addr_q <= data_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        index_d     = index_q;
        error_d     = error_q;
        status_d    = status_q;
        abort_d     = abort_q | (seq_abort & (state_q != StIdle));
        arm_d       = arm_q;
        word_d      = word_q;
        command_d   = command_q;
        count_d     = count_q;
        data_addr_d = data_addr_q;
        fetch_req   = 1'b0;
        case (state_q)
            StIdle: begin
                // A coincident abort is dropped: abort_d is cleared here
                if (seq_start) begin
                    addr_d    = seq_addr;
                    index_d   = '0;
                    error_d   = ErrOk;
                    status_d  = '0;
                    abort_d   = 1'b0;
                    fetch_req = 1'b1;
                    state_d   = StFetchAr;
                end
            end
            StFetchAr: if (mem_arvalid && mem_arready) state_d = StFetchR;
            StFetchR: begin
                if (rsp_valid) begin
                    if (rsp_err) begin
                        error_d = ErrFetch;
                        state_d = StEnd;
                    end else begin
                        word_d  = rsp_data;
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                command_d   = word_q[CcwCmdLsb +: 8];
                count_d     = word_q[CcwCountLsb +: 16];
                data_addr_d = word_q[CcwAddrLsb +: 32];
                // Fresh status per CCW so a stale modifier cannot skip a later CCW
                status_d    = '0;
                state_d     = StStart;
            end
            StStart: begin
                arm_d   = '0;
                state_d = StArm;
            end
            StArm: begin
                if (channel_active) begin
                    state_d = StRun;
                end else if (arm_q == ArmW'(START_WINDOW - 1)) begin
                    if (channel_condition_code != 2'b00) begin
                        error_d = ErrCc;
                        state_d = StEnd;
                    end else begin
                        state_d = StEval;
                    end
                end else begin
                    arm_d = arm_q + ArmW'(1);
                end
            end
            StRun: begin
                if (status_tvalid) status_d = status_tdata;
                if (!channel_active) state_d = StEval;
            end
            StEval: begin
                index_d = index_q + 16'd1;
                if ((status_q & (StsUnitCheck | StsUnitExc)) != 8'h00) begin
                    error_d = ErrUnit;
                    state_d = StEnd;
                end else if (abort_q) begin
                    error_d = ErrAbort;
                    state_d = StEnd;
                end else if (!cc_flag) begin
                    error_d = ErrOk;
                    state_d = StEnd;
                end else if (index_d == 16'(MAX_CCWS)) begin
                    error_d = ErrLimit;
                    state_d = StEnd;
                end else begin
                    addr_d    = next_ccw_addr(addr_q, status_q);
                    fetch_req = 1'b1;
                    state_d   = StFetchAr;
                end
            end
            StEnd:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (wd_expired) begin
            error_d = ErrWatchdog;
            state_d = StEnd;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WdW-1:0] wd_q, wd_d;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    always_comb begin
        wd_d = wd_q;
        if (state_q == StStart) begin
            wd_d = '0;
        end else if (state_q == StArm || state_q == StRun) begin
            wd_d = wd_q + WdW'(1);
        end
    end

    // The channel itself is left running; software owns its recovery
    assign wd_expired = (state_q == StArm || state_q == StRun) &&
                        (wd_q == WdW'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expired = 1'b0;

    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    logic unused_misc;
    assign unused_misc = ^{word_q[CcwFlagsLsb +: 8], FlagSli, StsChanDevEnd};

    assign seq_busy      = (state_q != StIdle) && (state_q != StEnd);
    assign seq_done      = (state_q == StEnd);
    assign seq_error     = error_q;
    assign seq_ccw_addr  = addr_q;
    assign seq_ccw_index = index_q;
    assign ccw_command   = command_q;
    assign ccw_count     = count_q;
    assign ccw_data_addr = data_addr_q;
    assign channel_start = (state_q == StStart);

endmodule

// File: tb/tb_ccw_chain_sequencer.sv
// Directed bench for ccw_chain_sequencer: memory and channel models feed scoreboards of
// expected fetch addresses, CCW fields and program end results.
module tb_ccw_chain_sequencer;

    localparam int unsigned StartWindow = 16;
    localparam int unsigned MaxCcws     = 256;
    localparam int          MaxWait     = 20000;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        seq_start, seq_abort;
    logic [31:0] seq_addr;
    logic        seq_busy, seq_done;
    logic [2:0]  seq_error;
    logic [31:0] seq_ccw_addr;
    logic [15:0] seq_ccw_index;
    logic [31:0] mem_araddr;
    logic        mem_arvalid, mem_arready;
    logic [63:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rvalid, mem_rready;
    logic [7:0]  ccw_command;
    logic [15:0] ccw_count;
    logic [31:0] ccw_data_addr;
    logic        channel_start, channel_active;
    logic [1:0]  channel_condition_code;
    logic [7:0]  status_tdata;
    logic        status_tvalid;

    ccw_chain_sequencer #(
        .START_WINDOW   (StartWindow),
        .MAX_CCWS       (MaxCcws),
        .TIMEOUT_CYCLES (1 << 24)
    ) dut (
        .aclk                   (aclk),
        .aresetn                (aresetn),
        .seq_start              (seq_start),
        .seq_abort              (seq_abort),
        .seq_addr               (seq_addr),
        .seq_busy               (seq_busy),
        .seq_done               (seq_done),
        .seq_error              (seq_error),
        .seq_ccw_addr           (seq_ccw_addr),
        .seq_ccw_index          (seq_ccw_index),
        .mem_araddr             (mem_araddr),
        .mem_arvalid            (mem_arvalid),
        .mem_arready            (mem_arready),
        .mem_rdata              (mem_rdata),
        .mem_rresp              (mem_rresp),
        .mem_rvalid             (mem_rvalid),
        .mem_rready             (mem_rready),
        .ccw_command            (ccw_command),
        .ccw_count              (ccw_count),
        .ccw_data_addr          (ccw_data_addr),
        .channel_start          (channel_start),
        .channel_active         (channel_active),
        .channel_condition_code (channel_condition_code),
        .status_tdata           (status_tdata),
        .status_tvalid          (status_tvalid)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [2:0]  err;
        logic [15:0] idx;
        logic [31:0] addr;
        logic [31:0] starts;
        int          lat;
    } res_t;

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] cnt;
        logic [31:0] daddr;
    } ccw_t;

    typedef struct {
        int         len;
        logic [7:0] status;
        logic [1:0] cc;
    } chan_t;

    logic [63:0] mem [logic [31:0]];
    logic [31:0] exp_fetch [$];
    res_t        exp_res [$];
    ccw_t        exp_ccw [$];
    chan_t       chan_q [$];

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned start_cyc = 0;
    int          starts = 0;
    int          done_cnt = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t mk_res(logic [2:0] e, logic [15:0] i, logic [31:0] a,
                                    logic [31:0] s, int lat);
        res_t r;
        r.err = e; r.idx = i; r.addr = a; r.starts = s; r.lat = lat;
        return r;
    endfunction

    // Place a CCW in memory; when it is expected to run, queue its fetch, fields and channel
    // behaviour (len 0 means channel_active never rises).
    task automatic add_ccw(input logic [31:0] a, input logic [7:0] cmd, input logic [7:0] flags,
                           input logic [15:0] cnt, input int len, input logic [7:0] status,
                           input logic [1:0] cc, input bit runs);
        ccw_t  c;
        chan_t b;
        mem[a] = {~a, cnt, flags, cmd};
        if (runs) begin
            c.cmd = cmd; c.cnt = cnt; c.daddr = ~a;
            b.len = len; b.status = status; b.cc = cc;
            exp_fetch.push_back(a);
            exp_ccw.push_back(c);
            chan_q.push_back(b);
        end
    endtask

    // Memory responder with random AR backpressure and 0-2 cycle read latency
    initial begin : mem_model
        logic        ar_hs, r_hs, rd_pending;
        logic [31:0] ar_a, rd_a, ef;
        int          rd_delay;
        rd_pending = 1'b0;
        rd_a = '0;
        rd_delay = 0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = '0;
        forever begin
            @(negedge aclk);
            ar_hs = mem_arvalid && mem_arready;
            r_hs  = mem_rvalid && mem_rready;
            ar_a  = mem_araddr;
            if (ar_hs) begin
                if (exp_fetch.size() > 0) ef = exp_fetch.pop_front();
                else ef = 'x;
                check("fetch_addr", ar_a, ef);
            end
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                mem_arready = 1'b0; mem_rvalid = 1'b0; rd_pending = 1'b0;
            end else begin
                if (r_hs) mem_rvalid = 1'b0;
                if (ar_hs) begin
                    mem_arready = 1'b0;
                    rd_pending = 1'b1;
                    rd_a = ar_a;
                    rd_delay = $urandom_range(0, 2);
                end else begin
                    mem_arready = ($urandom_range(0, 3) != 0);
                end
                if (rd_pending && !mem_rvalid) begin
                    if (rd_delay == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = mem.exists(rd_a) ? mem[rd_a] : 64'h0;
                        mem_rresp  = (err_en && rd_a == err_addr) ? 2'b10 : 2'b00;
                        rd_pending = 1'b0;
                    end else begin
                        rd_delay--;
                    end
                end
            end
        end
    end

    // Channel datapath model: checks loaded CCW fields on each start and plays back behaviour
    initial begin : chan_model
        ccw_t  c;
        chan_t b;
        channel_active = 1'b0; status_tvalid = 1'b0; status_tdata = '0;
        channel_condition_code = '0;
        forever begin
            @(negedge aclk);
            if (channel_start === 1'b1) begin
                starts++;
                start_cyc = cyc;
                if (exp_ccw.size() > 0) c = exp_ccw.pop_front();
                else begin c.cmd = 'x; c.cnt = 'x; c.daddr = 'x; end
                check("ccw_command", ccw_command, c.cmd);
                check("ccw_count", ccw_count, c.cnt);
                check("ccw_data_addr", ccw_data_addr, c.daddr);
                if (chan_q.size() > 0) b = chan_q.pop_front();
                else begin b.len = 0; b.status = 0; b.cc = 0; end
                @(posedge aclk);
                #1;
                channel_condition_code = b.cc;
                if (b.len > 0) begin
                    channel_active = 1'b1;
                    repeat (b.len - 1) @(posedge aclk);
                    #1;
                    status_tvalid = 1'b1;
                    status_tdata  = b.status;
                    @(posedge aclk);
                    #1;
                    status_tvalid = 1'b0;
                    channel_active = 1'b0;
                end
            end
        end
    end

    // End-of-program monitor
    initial begin : done_mon
        res_t r;
        int   prev_starts;
        prev_starts = 0;
        forever begin
            @(negedge aclk);
            if (seq_done === 1'b1) begin
                if (exp_res.size() > 0) r = exp_res.pop_front();
                else begin r.err = 'x; r.idx = 'x; r.addr = 'x; r.starts = 'x; r.lat = -1; end
                check("busy_at_done", seq_busy, 1'b0);
                check("seq_error", seq_error, r.err);
                check("seq_ccw_index", seq_ccw_index, r.idx);
                check("seq_ccw_addr", seq_ccw_addr, r.addr);
                check("channel_starts", starts - prev_starts, r.starts);
                if (r.lat >= 0) check("start_to_done", cyc - start_cyc, r.lat);
                prev_starts = starts;
                done_cnt++;
            end
        end
    end

    task automatic start_prog(input logic [31:0] a, input res_t r, input bit with_abort);
        exp_res.push_back(r);
        @(posedge aclk);
        #1;
        seq_addr  = a;
        seq_start = 1'b1;
        seq_abort = with_abort;
        @(posedge aclk);
        #1;
        seq_start = 1'b0;
        seq_abort = 1'b0;
        @(negedge aclk);
        check("busy_after_start", seq_busy, 1'b1);
    endtask

    task automatic wait_done(input logic [31:0] d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < MaxWait) begin
            @(posedge aclk);
            n++;
        end
        check("program_done", done_cnt != d0, 1'b1);
        @(negedge aclk);
        check("fetch_leftover", exp_fetch.size(), 0);
        if (done_cnt == d0) begin
            exp_fetch.delete(); exp_res.delete(); exp_ccw.delete(); chan_q.delete();
        end
    endtask

    task automatic run_prog(input logic [31:0] a, input res_t r, input bit with_abort);
        int d0;
        d0 = done_cnt;
        start_prog(a, r, with_abort);
        wait_done(d0);
    endtask

    initial begin : stimulus
        int d0, n;
        seq_start = 1'b0; seq_abort = 1'b0; seq_addr = '0;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("rst_busy", seq_busy, 1'b0);
        check("rst_done", seq_done, 1'b0);
        check("rst_error", seq_error, 3'd0);
        check("rst_arvalid", mem_arvalid, 1'b0);
        check("rst_rready", mem_rready, 1'b0);
        check("rst_chstart", channel_start, 1'b0);
        check("rst_index", seq_ccw_index, 16'd0);
        check("rst_ccw_addr", seq_ccw_addr, 32'd0);
        check("rst_ccw_count", ccw_count, 16'd0);
        @(posedge aclk);
        #1 aresetn = 1'b1;

        // Single CCW, active 10 cycles
        add_ccw(32'h100, 8'h01, 8'h00, 16'd4, 10, 8'h0C, 2'd0, 1'b1);
        run_prog(32'h100, mk_res(3'd0, 16'd1, 32'h100, 1, -1), 1'b0);

        // Three-CCW chain; a start while busy must be ignored
        add_ccw(32'h1000, 8'h02, 8'h40, 16'd8, 3, 8'h0C, 2'd0, 1'b1);
        add_ccw(32'h1008, 8'h03, 8'h40, 16'd9, 4, 8'h0C, 2'd0, 1'b1);
        add_ccw(32'h1010, 8'h04, 8'h00, 16'd10, 2, 8'h0C, 2'd0, 1'b1);
        d0 = done_cnt;
        start_prog(32'h1000, mk_res(3'd0, 16'd3, 32'h1010, 3, -1), 1'b0);
        repeat (4) @(posedge aclk);
        #1;
        seq_addr = 32'hDEAD_0000;
        seq_start = 1'b1;
        @(posedge aclk);
        #1 seq_start = 1'b0;
        wait_done(d0);

        // Status modifier skips one CCW
        add_ccw(32'h3000, 8'h05, 8'h40, 16'd1, 3, 8'h4C, 2'd0, 1'b1);
        add_ccw(32'h3008, 8'h06, 8'h00, 16'd2, 3, 8'h0C, 2'd0, 1'b0);
        add_ccw(32'h3010, 8'h07, 8'h00, 16'd3, 3, 8'h0C, 2'd0, 1'b1);
        run_prog(32'h3000, mk_res(3'd0, 16'd2, 32'h3010, 2, -1), 1'b0);

        // Fetch error
        mem[32'h4000] = 64'h0000_1234_0010_4001;
        exp_fetch.push_back(32'h4000);
        err_en = 1'b1; err_addr = 32'h4000;
        run_prog(32'h4000, mk_res(3'd1, 16'd0, 32'h4000, 0, -1), 1'b0);
        err_en = 1'b0;

        // Channel never becomes active: cc=3 is an error, cc=0 is immediate completion
        add_ccw(32'h5000, 8'h08, 8'h40, 16'd5, 0, 8'h00, 2'd3, 1'b1);
        run_prog(32'h5000, mk_res(3'd2, 16'd0, 32'h5000, 1, StartWindow + 1), 1'b0);
        add_ccw(32'h5100, 8'h09, 8'h00, 16'd6, 0, 8'h00, 2'd0, 1'b1);
        run_prog(32'h5100, mk_res(3'd0, 16'd1, 32'h5100, 1, StartWindow + 2), 1'b0);

        // Unit check on the second CCW stops the chain
        add_ccw(32'h6000, 8'h0A, 8'h40, 16'd1, 3, 8'h0C, 2'd0, 1'b1);
        add_ccw(32'h6008, 8'h0B, 8'h40, 16'd2, 3, 8'h0E, 2'd0, 1'b1);
        add_ccw(32'h6010, 8'h0C, 8'h00, 16'd3, 3, 8'h0C, 2'd0, 1'b0);
        run_prog(32'h6000, mk_res(3'd3, 16'd2, 32'h6008, 2, -1), 1'b0);

        // Abort while CCW1 runs
        add_ccw(32'h7000, 8'h0D, 8'h40, 16'd1, 3, 8'h0C, 2'd0, 1'b1);
        add_ccw(32'h7008, 8'h0E, 8'h40, 16'd2, 6, 8'h0C, 2'd0, 1'b1);
        add_ccw(32'h7010, 8'h0F, 8'h00, 16'd3, 3, 8'h0C, 2'd0, 1'b0);
        d0 = done_cnt;
        start_prog(32'h7000, mk_res(3'd6, 16'd2, 32'h7008, 2, -1), 1'b0);
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!(seq_ccw_addr == 32'h7008 && channel_active === 1'b1) && n < 500);
        @(posedge aclk);
        #1 seq_abort = 1'b1;
        @(posedge aclk);
        #1 seq_abort = 1'b0;
        wait_done(d0);

        // Start and abort together in IDLE: the abort is dropped
        add_ccw(32'h8000, 8'h10, 8'h40, 16'd1, 3, 8'h0C, 2'd0, 1'b1);
        add_ccw(32'h8008, 8'h11, 8'h00, 16'd2, 3, 8'h0C, 2'd0, 1'b1);
        run_prog(32'h8000, mk_res(3'd0, 16'd2, 32'h8008, 2, -1), 1'b1);

        // Address wrap modulo 2^32
        add_ccw(32'hFFFF_FFF8, 8'h12, 8'h40, 16'd7, 2, 8'h0C, 2'd0, 1'b1);
        add_ccw(32'h0000_0000, 8'h13, 8'h00, 16'd8, 2, 8'h0C, 2'd0, 1'b1);
        run_prog(32'hFFFF_FFF8, mk_res(3'd0, 16'd2, 32'h0, 2, -1), 1'b0);

        // Chain limit: every CCW chains
        for (int i = 0; i < int'(MaxCcws); i++) begin
            add_ccw(32'h9000 + 32'(i) * 8, 8'h20, 8'h40, 16'(i), 2, 8'h0C, 2'd0, 1'b1);
        end
        add_ccw(32'h9000 + 32'(MaxCcws) * 8, 8'h21, 8'h00, 16'd0, 2, 8'h0C, 2'd0, 1'b0);
        run_prog(32'h9000, mk_res(3'd4, 16'(MaxCcws), 32'h9000 + 32'(MaxCcws - 1) * 8,
                                  MaxCcws, -1), 1'b0);

        // Asynchronous reset in the middle of a fetch
        mem[32'hA000] = 64'h0000_2222_0040_0030;
        exp_fetch.push_back(32'hA000);
        @(posedge aclk);
        #1;
        seq_addr = 32'hA000;
        seq_start = 1'b1;
        @(posedge aclk);
        #1 seq_start = 1'b0;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (mem_rready !== 1'b1 && n < 100);
        #2 aresetn = 1'b0;
        #1;
        check("rst_mid_busy", seq_busy, 1'b0);
        check("rst_mid_rready", mem_rready, 1'b0);
        check("rst_mid_chstart", channel_start, 1'b0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;

        // Sequencer still usable after the reset
        add_ccw(32'hB000, 8'h30, 8'h00, 16'd9, 3, 8'h0C, 2'd0, 1'b1);
        run_prog(32'hB000, mk_res(3'd0, 16'd1, 32'hB000, 1, -1), 1'b0);

        check("res_leftover", exp_res.size(), 0);
        check("ccw_leftover", exp_ccw.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
